// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack handshake that carries one registered word across a clock domain crossing.
// Define CDC_TX_TIMEOUT_EN to abandon a request that is not acknowledged within TIMEOUT_CYCLES cycles.
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  xfer_req,
    output logic [DATA_WIDTH-1:0] xfer_data,
    input  logic                  xfer_ack,
    output logic                  done,
    output logic                  timeout_err,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_WIDTH-1:0]   ack_sync_q, ack_sync_d;
    logic                    xfer_req_q, xfer_req_d;
    logic [DATA_WIDTH-1:0]   xfer_data_q, xfer_data_d;
    logic                    done_q, done_d;
    logic                    ack_s;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    // Only the last synchronizer stage is trusted by the control logic.
    assign ack_s    = ack_sync_q[SYNC_WIDTH-1];
    assign in_ready = (state_q == IDLE) && !ack_s;

    always_comb begin
        state_d     = state_q;
        ack_sync_d  = {ack_sync_q[SYNC_WIDTH-2:0], xfer_ack};
        xfer_req_d  = xfer_req_q;
        xfer_data_d = xfer_data_q;
        done_d      = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    xfer_data_d = in_data;
                    xfer_req_d  = 1'b1;
                    state_d     = REQ;
`ifdef CDC_TX_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            REQ: begin
                // An ack arriving on the last allowed cycle still counts as success.
                if (ack_s) begin
                    done_d     = 1'b1;
                    xfer_req_d = 1'b0;
                    state_d    = RELEASE;
                end
`ifdef CDC_TX_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    xfer_req_d    = 1'b0;
                    state_d       = RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                xfer_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ack_sync_q  <= '0;
            xfer_req_q  <= 1'b0;
            xfer_data_q <= '0;
            done_q      <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ack_sync_q  <= ack_sync_d;
            xfer_req_q  <= xfer_req_d;
            xfer_data_q <= xfer_data_d;
            done_q      <= done_d;
`ifdef CDC_TX_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign xfer_req  = xfer_req_q;
    assign xfer_data = xfer_data_q;
    assign done      = done_q;
    assign state_dbg = state_q;

`ifdef CDC_TX_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: single transfer, streaming, data hold, mid-transfer reset, timeout, ack glitch.
// Inputs change 1 time unit after a posedge; outputs are sampled at that same point.
module tb_cdc_handshake_tx;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       xfer_req;
    logic [7:0] xfer_data;
    logic       xfer_ack;
    logic       done;
    logic       timeout_err;
    logic [1:0] state_dbg;

    // Destination model: either follows xfer_req (auto) or is driven directly.
    logic auto_ack;
    logic auto_ack_v;
    logic man_ack;
    assign xfer_ack = auto_ack ? auto_ack_v : man_ack;

    int n_cmp;
    int n_err;
    int done_cnt;
    int done_base;
    logic       prev_req;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    cdc_handshake_tx #(
        .DATA_WIDTH    (8),
        .SYNC_WIDTH    (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .xfer_req   (xfer_req),
        .xfer_data  (xfer_data),
        .xfer_ack   (xfer_ack),
        .done       (done),
        .timeout_err(timeout_err),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (in_ready) break;
            tick();
        end
        chk(tag, 32'(in_ready), 1);
    endtask

    // Monitor: record each new request word, check ready is low during a request,
    // count done pulses and check done/timeout_err never coincide.
    always @(negedge clk) begin
        auto_ack_v = xfer_req;
        if (done) done_cnt++;
        if (xfer_req && !prev_req) got_q.push_back(xfer_data);
        if (xfer_req) chk("ready_low_in_xfer", 32'(in_ready), 0);
        if (done || timeout_err) chk("done_xor_timeout", 32'(done && timeout_err), 0);
        prev_req = xfer_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; done_cnt = 0; prev_req = 1'b0;
        auto_ack = 1'b0; auto_ack_v = 1'b0; man_ack = 1'b0;
        in_valid = 1'b0; in_data = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_xfer_req", 32'(xfer_req), 0);
        chk("rst_xfer_data", 32'(xfer_data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_state", 32'(state_dbg), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single word A5; ack rises 3 cycles after req, falls 3 cycles after req drops.
        done_base = done_cnt;
        in_valid = 1'b1; in_data = 8'hA5;
        chk("s1_ready_before", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        chk("s1_req_up", 32'(xfer_req), 1);
        chk("s1_data", 32'(xfer_data), 'hA5);
        chk("s1_ready_busy", 32'(in_ready), 0);
        chk("s1_state_req", 32'(state_dbg), 1);
        tick(); tick(); tick();
        man_ack = 1'b1;
        tick();
        chk("s1_req_hold1", 32'(xfer_req), 1);
        tick();
        chk("s1_req_hold2", 32'(xfer_req), 1);
        chk("s1_no_done_yet", 32'(done), 0);
        tick();
        chk("s1_done", 32'(done), 1);
        chk("s1_req_down", 32'(xfer_req), 0);
        chk("s1_data_release", 32'(xfer_data), 'hA5);
        chk("s1_state_release", 32'(state_dbg), 2);
        tick();
        chk("s1_done_pulse", 32'(done), 0);
        tick(); tick();
        man_ack = 1'b0;
        tick();
        chk("s1_release_hold", 32'(state_dbg), 2);
        chk("s1_ready_release", 32'(in_ready), 0);
        chk("s1_data_hold", 32'(xfer_data), 'hA5);
        tick();
        chk("s1_ready_release2", 32'(in_ready), 0);
        tick();
        chk("s1_idle", 32'(state_dbg), 0);
        chk("s1_ready_idle", 32'(in_ready), 1);
        chk("s1_done_count", 32'(done_cnt - done_base), 1);

        // Stream 11, 22, 33 with in_valid held high throughout.
        auto_ack = 1'b1;
        got_q.delete();
        exp_q.delete();
        done_base = done_cnt;
        in_valid = 1'b1;
        in_data = 8'h11;
        wait_ready("s2_wait_11");
        tick();
        exp_q.push_back(8'h11);
        in_data = 8'h22;
        wait_ready("s2_wait_22");
        tick();
        exp_q.push_back(8'h22);
        in_data = 8'h33;
        wait_ready("s2_wait_33");
        tick();
        exp_q.push_back(8'h33);
        in_valid = 1'b0;
        wait_ready("s2_wait_end");
        chk("s2_word_count", 32'(got_q.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) chk("s2_word", 32'(got_q[i]), 32'(exp_q[i]));
        end
        chk("s2_done_count", 32'(done_cnt - done_base), 3);

        // Input changes to FF during REQ must not disturb the captured word.
        auto_ack = 1'b0;
        man_ack = 1'b0;
        in_valid = 1'b1; in_data = 8'h5C;
        wait_ready("s3_wait");
        tick();
        in_data = 8'hFF;
        chk("s3_capture", 32'(xfer_data), 'h5C);
        tick(); tick(); tick();
        chk("s3_hold_req", 32'(xfer_data), 'h5C);
        chk("s3_req_still", 32'(xfer_req), 1);
        man_ack = 1'b1;
        tick(); tick(); tick();
        chk("s3_release", 32'(state_dbg), 2);
        chk("s3_hold_release", 32'(xfer_data), 'h5C);
        man_ack = 1'b0;
        tick(); tick(); tick();
        chk("s3_idle", 32'(state_dbg), 0);
        chk("s3_hold_idle", 32'(xfer_data), 'h5C);
        tick();
        chk("s3_next_capture", 32'(xfer_data), 'hFF);
        chk("s3_next_req", 32'(xfer_req), 1);
        in_valid = 1'b0;
        auto_ack = 1'b1;
        wait_ready("s3_wait_end");

        // Reset pulse while requesting.
        auto_ack = 1'b0;
        man_ack = 1'b0;
        in_valid = 1'b1; in_data = 8'h3C;
        wait_ready("s4_wait");
        tick();
        in_valid = 1'b0;
        tick();
        chk("s4_req_up", 32'(xfer_req), 1);
        done_base = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("s4_rst_req", 32'(xfer_req), 0);
        chk("s4_rst_data", 32'(xfer_data), 0);
        chk("s4_rst_done", 32'(done), 0);
        chk("s4_rst_state", 32'(state_dbg), 0);
        #3 rst_n = 1'b1;
        tick();
        chk("s4_ready_after", 32'(in_ready), 1);
        chk("s4_req_after", 32'(xfer_req), 0);
        chk("s4_no_done", 32'(done_cnt - done_base), 0);

        // Request that is never acknowledged.
        done_base = done_cnt;
        in_valid = 1'b1; in_data = 8'h77;
        wait_ready("s5_wait");
        tick();
        in_valid = 1'b0;
        chk("s5_req_up", 32'(xfer_req), 1);
`ifdef CDC_TX_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("s5_req_wait", 32'(xfer_req), 1);
            chk("s5_no_timeout_yet", 32'(timeout_err), 0);
        end
        tick();
        chk("s5_timeout", 32'(timeout_err), 1);
        chk("s5_req_dropped", 32'(xfer_req), 0);
        chk("s5_no_done", 32'(done), 0);
        tick();
        chk("s5_timeout_pulse", 32'(timeout_err), 0);
        chk("s5_idle", 32'(state_dbg), 0);
        chk("s5_ready", 32'(in_ready), 1);
        chk("s5_done_count", 32'(done_cnt - done_base), 0);
`else
        for (int i = 0; i < 40; i++) tick();
        chk("s5_req_waits", 32'(xfer_req), 1);
        chk("s5_timeout_tied", 32'(timeout_err), 0);
        chk("s5_no_done", 32'(done_cnt - done_base), 0);
        auto_ack = 1'b1;
        wait_ready("s5_wait_end");
        auto_ack = 1'b0;
`endif

        // Ack glitch of 5 cycles while idle.
        man_ack = 1'b0;
        tick(); tick();
        done_base = done_cnt;
        man_ack = 1'b1;
        tick();
        chk("s6_ready_e1", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s6_ready_low", 32'(in_ready), 0);
            chk("s6_no_req", 32'(xfer_req), 0);
        end
        man_ack = 1'b0;
        tick();
        chk("s6_ready_low_tail", 32'(in_ready), 0);
        tick();
        chk("s6_ready_back", 32'(in_ready), 1);
        chk("s6_state", 32'(state_dbg), 0);
        chk("s6_no_done", 32'(done_cnt - done_base), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
